// File: rtl/ip_encoder.sv
// IPv4 header encoder: header words from edge k+1 after start, then buffered payload; no downstream backpressure.
// Macro IP_ENCODER_OPTIONS_EN makes header length follow IHL (zero option words); otherwise 5 header words.

module ip_encoder_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign pop_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= push_dat;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop && !empty)
                rd_ptr <= rd_ptr + PTR_ONE;
        end
    end
endmodule

module ip_encoder #(
    parameter int BUF_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  version,
    input  logic [3:0]  IHL,
    input  logic [7:0]  type_of_ser,
    input  logic [15:0] total_length,
    input  logic [15:0] identification,
    input  logic [2:0]  flag,
    input  logic [12:0] frag_offset,
    input  logic [7:0]  time_to_live,
    input  logic [7:0]  protocol,
    input  logic [31:0] src_ip,
    input  logic [31:0] dest_ip,
    input  logic        check,
    input  logic [15:0] checksum_in,
    input  logic [15:0] len_in,
    input  logic [31:0] data,
    input  logic        data_av,
    output logic [31:0] pkg_data,
    output logic        wr_en,
    output logic        fin,
    output logic [15:0] len_out,
    output logic [15:0] checksum_out
);
    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} state_t;

    typedef struct packed {
        logic [3:0]  version;
        logic [3:0]  ihl;
        logic [7:0]  tos;
        logic [15:0] total_length;
        logic [15:0] identification;
        logic [2:0]  flag;
        logic [12:0] frag_offset;
        logic [7:0]  ttl;
        logic [7:0]  protocol;
        logic [31:0] src_ip;
        logic [31:0] dest_ip;
        logic        check;
        logic [15:0] checksum_in;
        logic [15:0] len;
    } hdr_t;

    state_t      state, state_nxt;
    hdr_t        hdr_q;
    logic [14:0] need_in, need_q;
    logic [14:0] acc_cnt, out_cnt;
    logic [3:0]  hdr_cnt;
    logic [3:0]  nhdr;
    logic [15:0] len_total;

    logic        push, pop, empty, full;
    logic [31:0] pop_dat;
    logic        cap_en;
    logic [14:0] cap_cnt, cap_need;

    logic [19:0] csum_sum;
    logic [16:0] csum_f1;
    logic [15:0] csum_f2, csum_hdr;
    logic [31:0] hdr_word;

    logic [31:0] pkg_nxt;
    logic        wr_nxt, fin_nxt;

    assign need_in = 15'((17'(len_in) + 17'd3) >> 2);

`ifdef IP_ENCODER_OPTIONS_EN
    assign nhdr      = (hdr_q.ihl < 4'd5) ? 4'd5 : hdr_q.ihl;
    assign len_total = {10'd0, nhdr, 2'b00} + hdr_q.len;
`else
    assign nhdr      = 4'd5;
    assign len_total = 16'd20 + hdr_q.len;
`endif

    // Option words are zero, so only the fixed fields contribute to the sum.
    always_comb begin
        csum_sum = 20'({hdr_q.version, hdr_q.ihl, hdr_q.tos}) + 20'(hdr_q.total_length)
                 + 20'(hdr_q.identification) + 20'({hdr_q.flag, hdr_q.frag_offset})
                 + 20'({hdr_q.ttl, hdr_q.protocol})
                 + 20'(hdr_q.src_ip[31:16]) + 20'(hdr_q.src_ip[15:0])
                 + 20'(hdr_q.dest_ip[31:16]) + 20'(hdr_q.dest_ip[15:0]);
        csum_f1  = 17'(csum_sum[15:0]) + 17'(csum_sum[19:16]);
        csum_f2  = csum_f1[15:0] + 16'(csum_f1[16]);
        csum_hdr = hdr_q.check ? ~csum_f2 : hdr_q.checksum_in;
    end

    always_comb begin
        hdr_word = 32'h0;
        case (hdr_cnt)
            4'd0: hdr_word = {hdr_q.version, hdr_q.ihl, hdr_q.tos, hdr_q.total_length};
            4'd1: hdr_word = {hdr_q.identification, hdr_q.flag, hdr_q.frag_offset};
            4'd2: hdr_word = {hdr_q.ttl, hdr_q.protocol, csum_hdr};
            4'd3: hdr_word = hdr_q.src_ip;
            4'd4: hdr_word = dest_ip_word();
            default: hdr_word = 32'h0;
        endcase
    end

    function automatic logic [31:0] dest_ip_word();
        return hdr_q.dest_ip;
    endfunction

    // Capture starts in the start cycle itself, using the live len_in.
    always_comb begin
        cap_en   = 1'b1;
        cap_cnt  = acc_cnt;
        cap_need = need_q;
        if (state == IDLE) begin
            cap_en   = start;
            cap_cnt  = '0;
            cap_need = need_in;
        end
        push = cap_en && data_av && (cap_cnt < cap_need) && !full;
    end

    ip_encoder_fifo #(.WIDTH(32), .DEPTH(BUF_DEPTH)) u_buf (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_dat (data),
        .pop      (pop),
        .pop_dat  (pop_dat),
        .empty    (empty),
        .full     (full)
    );

    always_comb begin
        state_nxt = state;
        pkg_nxt   = pkg_data;
        wr_nxt    = 1'b0;
        fin_nxt   = 1'b0;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (start)
                    state_nxt = HEADER;
            end
            HEADER: begin
                pkg_nxt = hdr_word;
                wr_nxt  = 1'b1;
                if (hdr_cnt == nhdr - 4'd1) begin
                    if (need_q == '0) begin
                        fin_nxt   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (!empty) begin
                    pop     = 1'b1;
                    pkg_nxt = pop_dat;
                    wr_nxt  = 1'b1;
                    if (out_cnt == need_q - 15'd1) begin
                        fin_nxt   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            hdr_q        <= '0;
            need_q       <= '0;
            hdr_cnt      <= '0;
            acc_cnt      <= '0;
            out_cnt      <= '0;
            pkg_data     <= '0;
            wr_en        <= 1'b0;
            fin          <= 1'b0;
            len_out      <= '0;
            checksum_out <= '0;
        end else begin
            state    <= state_nxt;
            pkg_data <= pkg_nxt;
            wr_en    <= wr_nxt;
            fin      <= fin_nxt;
            if (state == IDLE && start) begin
                hdr_q <= '{version: version, ihl: IHL, tos: type_of_ser,
                           total_length: total_length, identification: identification,
                           flag: flag, frag_offset: frag_offset, ttl: time_to_live,
                           protocol: protocol, src_ip: src_ip, dest_ip: dest_ip,
                           check: check, checksum_in: checksum_in, len: len_in};
                need_q  <= need_in;
                hdr_cnt <= '0;
                out_cnt <= '0;
                acc_cnt <= push ? 15'd1 : 15'd0;
            end else begin
                if (push)
                    acc_cnt <= acc_cnt + 15'd1;
                if (state == HEADER)
                    hdr_cnt <= hdr_cnt + 4'd1;
                if (pop)
                    out_cnt <= out_cnt + 15'd1;
            end
            if (state == HEADER && hdr_cnt == 4'd0) begin
                len_out      <= len_total;
                checksum_out <= csum_hdr;
            end
        end
    end
endmodule

// File: tb/tb_ip_encoder.sv
// Scoreboard bench for ip_encoder: expected words queued at stimulus time, popped by a negedge monitor.
module tb_ip_encoder;
    localparam logic [31:0] SRC = 32'h9801331B;
    localparam logic [31:0] DST = 32'h980E5E4B;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  version, ihl;
    logic [7:0]  type_of_ser;
    logic [15:0] total_length, identification;
    logic [2:0]  flag;
    logic [12:0] frag_offset;
    logic [7:0]  time_to_live, protocol;
    logic [31:0] src_ip, dest_ip;
    logic        check;
    logic [15:0] checksum_in, len_in;
    logic [31:0] data;
    logic        data_av;
    logic [31:0] pkg_data;
    logic        wr_en, fin;
    logic [15:0] len_out, checksum_out;

    ip_encoder #(.BUF_DEPTH(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .version        (version),
        .IHL            (ihl),
        .type_of_ser    (type_of_ser),
        .total_length   (total_length),
        .identification (identification),
        .flag           (flag),
        .frag_offset    (frag_offset),
        .time_to_live   (time_to_live),
        .protocol       (protocol),
        .src_ip         (src_ip),
        .dest_ip        (dest_ip),
        .check          (check),
        .checksum_in    (checksum_in),
        .len_in         (len_in),
        .data           (data),
        .data_av        (data_av),
        .pkg_data       (pkg_data),
        .wr_en          (wr_en),
        .fin            (fin),
        .len_out        (len_out),
        .checksum_out   (checksum_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] dat;
        logic        fin;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] pay [8];
    logic [31:0] hdr_std [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_pkg_data"}, pkg_data, 32'h0);
        chk({tag, "_wr_en"}, {31'd0, wr_en}, 32'd0);
        chk({tag, "_fin"}, {31'd0, fin}, 32'd0);
        chk({tag, "_len_out"}, {16'd0, len_out}, 32'd0);
        chk({tag, "_checksum_out"}, {16'd0, checksum_out}, 32'd0);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (wr_en) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_word: got %h fin %0b, expected no word at %0t", pkg_data, fin, $time);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("word", pkg_data, e.dat);
                    chk("fin", {31'd0, fin}, {31'd0, e.fin});
                end
            end else if (fin) begin
                checks++;
                errors++;
                $display("FAIL fin_without_wr_en: got fin 1, expected 0 at %0t", $time);
            end
        end
    end

    // One packet; called just after a rising edge. abort_c > 0 asserts reset after that edge.
    task automatic send(input logic chk_en, input logic [15:0] cin, input logic [15:0] len,
                        input int nwords, input logic [15:0] mask, input logic [31:0] w2_exp,
                        input logic [15:0] len_exp, input logic [15:0] cs_exp,
                        input bit busy, input int abort_c);
        int   idx;
        bit   junk_sent;
        int   n_exp;
        exp_t e;
        n_exp = (abort_c > 0) ? 7 : 5 + nwords;
        for (int i = 0; i < n_exp; i++) begin
            e.dat = (i < 5) ? ((i == 2) ? w2_exp : hdr_std[i]) : pay[i-5];
            e.fin = (abort_c == 0) && (i == n_exp - 1);
            exp_q.push_back(e);
        end
        check       = chk_en;
        checksum_in = cin;
        len_in      = len;
        idx         = 0;
        junk_sent   = 1'b0;
        for (int c = 0; c < 24; c++) begin
            data_av = 1'b0;
            if ((c >= 16 || mask[c[3:0]]) && !junk_sent) begin
                if (idx < nwords) begin
                    data = pay[idx];
                end else begin
                    data      = 32'hFFFFFFFF;
                    junk_sent = 1'b1;
                end
                idx++;
                data_av = 1'b1;
            end
            start  = (c == 0) || (busy && c == 2);
            src_ip = (busy && c == 2) ? 32'h0 : SRC;
            @(posedge clk);
            #1;
            if (c == 1) begin
                chk("len_out", {16'd0, len_out}, {16'd0, len_exp});
                chk("checksum_out", {16'd0, checksum_out}, {16'd0, cs_exp});
            end
            if (abort_c > 0 && c == abort_c) begin
                reset = 1'b1;
                #1;
                chk_reset_outputs("abort");
                break;
            end
            if (abort_c == 0 && junk_sent && c >= 2)
                break;
        end
        start   = 1'b0;
        data_av = 1'b0;
        src_ip  = SRC;
        if (abort_c > 0) begin
            chk("abort_drain", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
            repeat (2) @(posedge clk);
            #1;
            reset = 1'b0;
            @(posedge clk);
            #1;
        end else begin
            for (int t = 0; t < 60 && exp_q.size() != 0; t++)
                @(posedge clk);
            chk("pending_words", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
            repeat (3) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset          = 1'b1;
        start          = 1'b0;
        data           = 32'h0;
        data_av        = 1'b0;
        version        = 4'd4;
        ihl            = 4'd5;
        type_of_ser    = 8'h00;
        total_length   = 16'h002A;
        identification = 16'h1234;
        flag           = 3'd0;
        frag_offset    = 13'h123;
        time_to_live   = 8'h10;
        protocol       = 8'd17;
        src_ip         = SRC;
        dest_ip        = DST;
        check          = 1'b1;
        checksum_in    = 16'h0;
        len_in         = 16'd0;
        pay     = '{32'h48656C6C, 32'h6F20576F, 32'h726C6448, 32'h656C6C6F,
                    32'h20576F72, 32'h6C640000, 32'h0, 32'h0};
        hdr_std = '{32'h4500002A, 32'h12340123, 32'h1011D5F6, SRC, DST};

        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Gapped payload, computed checksum
        send(1'b1, 16'h0000, 16'd22, 6, 16'h306D, 32'h1011D5F6, 16'h002A, 16'hD5F6, 1'b0, 0);
        // Checksum pass-through
        send(1'b0, 16'hBEEF, 16'd22, 6, 16'hFFFF, 32'h1011BEEF, 16'h002A, 16'hBEEF, 1'b0, 0);
        // Reset during the third payload word, then a clean packet
        send(1'b1, 16'h0000, 16'd22, 6, 16'hFFFF, 32'h1011D5F6, 16'h002A, 16'hD5F6, 1'b0, 8);
        send(1'b1, 16'h0000, 16'd22, 6, 16'hFFFF, 32'h1011D5F6, 16'h002A, 16'hD5F6, 1'b0, 0);
        // Zero length with a start pulse during HEADER
        send(1'b1, 16'h0000, 16'd0, 0, 16'hFFFF, 32'h1011D5F6, 16'h0014, 16'hD5F6, 1'b1, 0);
        // Non-multiple-of-4 short payload
        send(1'b1, 16'h0000, 16'd5, 2, 16'hFFFF, 32'h1011D5F6, 16'h0019, 16'hD5F6, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ip_encoder.md
# ip_encoder

IPv4 transmit-path header encoder. Latches the IPv4 header fields on `start` and emits a 32-bit-word packet: IHL header words followed by the payload words streamed in on `data`/`data_av`. It sits between the TCP/UDP segment encoder (upstream) and the link-layer/frame buffer (downstream, written via `wr_en`). The header checksum is computed internally, or passed through from `checksum_in`.

## Interface
Parameters:
- `BUF_DEPTH`, 8: payload buffer depth in 32-bit words (power of two).

Ports:
- `clk`  in  1  — single clock; all logic on rising edge.
- `reset`  in  1  — asynchronous, active-high reset.
- `start`  in  1  — begin packet; sampled in IDLE only.
- `version`, `IHL`  in  4 each  — header fields.
- `type_of_ser`  in  8, `total_length`  in  16, `identification`  in  16  — header fields.
- `flag`  in  3, `frag_offset`  in  13, `time_to_live`  in  8, `protocol`  in  8  — header fields.
- `src_ip`, `dest_ip`  in  32 each  — addresses.
- `check`  in  1  — 1: compute header checksum; 0: insert `checksum_in`.
- `checksum_in`  in  16  — externally supplied checksum.
- `len_in`  in  16  — payload length in bytes.
- `data`  in  32  — payload word, MSB-first bytes; last word zero-padded on the right.
- `data_av`  in  1  — `data` valid this cycle.
- `pkg_data`  out  32  — output word.
- `wr_en`  out  1  — `pkg_data` valid.
- `fin`  out  1  — one-cycle pulse with the last word of the packet.
- `len_out`  out  16  — total packet bytes = `IHL`*4 + `len_in`.
- `checksum_out`  out  16  — checksum value placed in header.

## Operation
- States: IDLE, HEADER, PAYLOAD.
- IDLE: on `start`=1, latch all header inputs, `len_in`, `check`, `checksum_in`; clear counters; go to HEADER. `data` with `data_av`=1 in the start cycle is payload word 0.
- Payload capture runs in parallel from the start cycle: each `data_av`=1 cycle pushes `data` into the buffer until ceil(`len_in`/4) words are accepted. Further words are ignored. Words arriving with the buffer full are dropped.
- HEADER: one word per cycle:
  - w0 = {version, IHL, type_of_ser, total_length}
  - w1 = {identification, flag, frag_offset}
  - w2 = {time_to_live, protocol, checksum}
  - w3 = src_ip
  - w4 = dest_ip
  - then the option words (see Configuration).
- Checksum = ~(one's-complement 16-bit sum of header halfwords with the checksum field as 0), with end-around carry folded twice.
- PAYLOAD: pop one buffered word per cycle when the buffer is non-empty, with `wr_en`=1. When the buffer is empty, `wr_en`=0 and `pkg_data` holds its value. After the last payload word, return to IDLE.
- `len_in`=0: `fin` is asserted with the last header word and the FSM goes directly to IDLE.
- `start` while not IDLE is ignored.

## Timing
- All outputs are registered. On reset: `pkg_data`=0, `wr_en`=0, `fin`=0, `len_out`=0, `checksum_out`=0, buffer empty, state IDLE.
- Reset mid-packet aborts the packet immediately. No `fin` is produced.
- `start` sampled at edge k: header w0 appears after edge k+1, wi after edge k+1+i, then payload from edge k+1+IHL_emitted at the earliest.
- `len_out` and `checksum_out` are valid after edge k+1 and hold until the next accepted `start`.
- `fin` is high exactly in the cycle carrying the last word, coincident with `wr_en`=1.
- Throughput: at most one word per cycle; no backpressure from downstream.

## Configuration
- `IP_ENCODER_OPTIONS_EN` defined: header length follows `IHL` (5..15). Words 5..IHL-1 are emitted as 0x00000000. IHL<5 is treated as 5. `len_out` uses `IHL`.
- Not defined: exactly 5 header words are emitted. The IHL field is emitted as given, but `len_out` = 20 + `len_in`.

## Test plan
- Basic header (`check`=1):
  - Stimulus: ver 4, IHL 5, TOS 0, total_length 0x002A, id 0x1234, flag 0, frag 0x123, TTL 0x10, proto 17, src 0x9801331B, dst 0x980E5E4B, `len_in` 22.
  - Required: header words 0x4500002A, 0x12340123, 0x1011D5F6, 0x9801331B, 0x980E5E4B; `checksum_out`=0xD5F6; `len_out`=0x002A.
- Gapped payload:
  - Stimulus: same packet, "Hello WorldHello World" supplied in 6 words with `data_av` gaps, starting in the start cycle.
  - Required: after the header, 0x48656C6C, 0x6F20576F, 0x726C6448, 0x656C6C6F, 0x20576F72, 0x6C640000; `fin` with the last word; IDLE afterwards.
- Checksum pass-through:
  - Stimulus: `check`=0, `checksum_in`=0xBEEF.
  - Required: w2 = 0x1011BEEF; `checksum_out`=0xBEEF.
- Reset mid-payload:
  - Stimulus: assert `reset` during the 3rd payload word.
  - Required: all outputs 0 in the same cycle, no `fin`; a new `start` produces a correct full packet.
- Busy start / zero length:
  - Stimulus: `start` pulsed during HEADER.
  - Required: ignored.
  - Stimulus: `len_in`=0.
  - Required: 5 header words, `fin` on w4.
